// File: rtl/gps_frame_parser.sv
// gps_frame_parser: parses Motorola-style binary "@@Ha" position/status frames
// from a UART byte stream. It hunts for the header, checks the ID, XOR checksum
// and CR/LF trailer, and publishes the decoded fields atomically on good frames.
// Also provides frame statistics, an inter-byte timeout and a synchronised
// 1PPS strobe.
// Optional build macro GPS_PPS_STAMP_EN: latches a free-running cycle counter
// into PPS_STAMP on each PPS strobe. When the macro is undefined, PPS_STAMP is 0.
module gps_frame_parser #(
    parameter int         CHANNELS    = 12,
    parameter logic [7:0] MSG_ID0     = 8'h48,
    parameter logic [7:0] MSG_ID1     = 8'h61,
    parameter int         TIMEOUT_CYC = 20000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    input  logic        GPS_PPS,
    output logic [15:0] GPS_YEAR,
    output logic [7:0]  GPS_MONTH,
    output logic [7:0]  GPS_DAY,
    output logic [7:0]  GPS_HOUR,
    output logic [7:0]  GPS_MINUTES,
    output logic [7:0]  GPS_SECOND,
    output logic [31:0] GPS_LATITUDE,
    output logic [31:0] GPS_LONGITUDE,
    output logic [31:0] GPS_HEIGHT,
    output logic [31:0] GPS_ALTITUDE,
    output logic [7:0]  GPS_VISIBLE_SATS,
    output logic [7:0]  GPS_TRACKED_SATS,
    output logic        GPS_LOCKED,
    output logic        FRAME_VALID,
    output logic [15:0] FRAME_OK_CNT,
    output logic [15:0] FRAME_ERR_CNT,
    output logic        PPS_STROBE,
    output logic [31:0] PPS_STAMP
);

    // Total frame length including "@@" and CR/LF; derived from CHANNELS only.
    localparam int         FRAME_LEN = 82 + 6 * CHANNELS;
    localparam logic [7:0] LAST_BODY = 8'(FRAME_LEN - 4);
    localparam int         TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] ST_HUNT1 = 3'd0;
    localparam logic [2:0] ST_HUNT2 = 3'd1;
    localparam logic [2:0] ST_ID0   = 3'd2;
    localparam logic [2:0] ST_ID1   = 3'd3;
    localparam logic [2:0] ST_BODY  = 3'd4;
    localparam logic [2:0] ST_CKSUM = 3'd5;
    localparam logic [2:0] ST_CR    = 3'd6;
    localparam logic [2:0] ST_LF    = 3'd7;

    logic [2:0]       state_reg, state_next;
    logic [7:0]       idx_reg, idx_next;
    logic [7:0]       cksum_reg, cksum_next;
    logic             err_reg, err_next;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic             commit, frame_bad, timeout_hit;

    logic [15:0] sh_year;
    logic [7:0]  sh_month, sh_day, sh_hour, sh_min, sh_sec, sh_vis, sh_trk;
    logic [31:0] sh_lat, sh_lon, sh_height, sh_alt;
    logic        sh_locked;

    // One bit per channel record: the current byte is that channel's status byte.
    logic [CHANNELS-1:0] lock_hit;
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lock
            assign lock_hit[gi] = (idx_reg == 8'(58 + 6 * gi));
        end
    endgenerate

    // Parser next-state: header hunt, running checksum, trailer checks, idle timeout.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        cksum_next  = cksum_reg;
        err_next    = err_reg;
        tmo_next    = tmo_reg;
        commit      = 1'b0;
        frame_bad   = 1'b0;
        timeout_hit = 1'b0;
        if (state_reg == ST_HUNT1) begin
            tmo_next = '0;
        end else if (!RX_VALID) begin
            if (tmo_reg == TMO_LAST) begin
                timeout_hit = 1'b1;
                state_next  = ST_HUNT1;
                tmo_next    = '0;
            end else begin
                tmo_next = tmo_reg + TMO_W'(1);
            end
        end else begin
            tmo_next = '0;
        end
        if (RX_VALID) begin
            case (state_reg)
                ST_HUNT1: if (RX_DATA == 8'h40) state_next = ST_HUNT2;
                ST_HUNT2: state_next = (RX_DATA == 8'h40) ? ST_ID0 : ST_HUNT1;
                ST_ID0: begin
                    if (RX_DATA == MSG_ID0) begin
                        state_next = ST_ID1;
                        cksum_next = RX_DATA;
                    end else if (RX_DATA != 8'h40) begin
                        state_next = ST_HUNT1;
                    end
                end
                ST_ID1: begin
                    if (RX_DATA == MSG_ID1) begin
                        state_next = ST_BODY;
                        cksum_next = cksum_reg ^ RX_DATA;
                        idx_next   = 8'd4;
                        err_next   = 1'b0;
                    end else begin
                        state_next = ST_HUNT1;
                    end
                end
                ST_BODY: begin
                    cksum_next = cksum_reg ^ RX_DATA;
                    if (idx_reg == LAST_BODY) state_next = ST_CKSUM;
                    else                      idx_next   = idx_reg + 8'd1;
                end
                ST_CKSUM: begin
                    if (RX_DATA != cksum_reg) err_next = 1'b1;
                    state_next = ST_CR;
                end
                ST_CR: begin
                    if (RX_DATA != 8'h0D) err_next = 1'b1;
                    state_next = ST_LF;
                end
                default: begin
                    if (!err_reg && RX_DATA == 8'h0A) commit    = 1'b1;
                    else                              frame_bad = 1'b1;
                    state_next = ST_HUNT1;
                end
            endcase
        end
    end

    // Parser state registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_HUNT1;
            idx_reg   <= '0;
            cksum_reg <= '0;
            err_reg   <= 1'b0;
            tmo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cksum_reg <= cksum_next;
            err_reg   <= err_next;
            tmo_reg   <= tmo_next;
        end
    end

    // Capture field bytes into shadow registers while the body streams past.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sh_year <= '0; sh_month <= '0; sh_day <= '0; sh_hour <= '0;
            sh_min <= '0; sh_sec <= '0; sh_vis <= '0; sh_trk <= '0;
            sh_lat <= '0; sh_lon <= '0; sh_height <= '0; sh_alt <= '0;
            sh_locked <= 1'b0;
        end else if (RX_VALID && state_reg == ST_ID1) begin
            sh_locked <= 1'b0;
        end else if (RX_VALID && state_reg == ST_BODY) begin
            case (idx_reg)
                8'd4:                      sh_month  <= RX_DATA;
                8'd5:                      sh_day    <= RX_DATA;
                8'd6, 8'd7:                sh_year   <= {sh_year[7:0], RX_DATA};
                8'd8:                      sh_hour   <= RX_DATA;
                8'd9:                      sh_min    <= RX_DATA;
                8'd10:                     sh_sec    <= RX_DATA;
                8'd15, 8'd16, 8'd17, 8'd18: sh_lat    <= {sh_lat[23:0], RX_DATA};
                8'd19, 8'd20, 8'd21, 8'd22: sh_lon    <= {sh_lon[23:0], RX_DATA};
                8'd23, 8'd24, 8'd25, 8'd26: sh_height <= {sh_height[23:0], RX_DATA};
                8'd27, 8'd28, 8'd29, 8'd30: sh_alt    <= {sh_alt[23:0], RX_DATA};
                8'd55:                     sh_vis    <= RX_DATA;
                8'd56:                     sh_trk    <= RX_DATA;
                default: ;
            endcase
            if ((|lock_hit) && RX_DATA[3]) sh_locked <= 1'b1;
        end
    end

    // Publish shadows on a good frame and keep saturating frame statistics.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            GPS_YEAR <= '0; GPS_MONTH <= '0; GPS_DAY <= '0; GPS_HOUR <= '0;
            GPS_MINUTES <= '0; GPS_SECOND <= '0; GPS_LATITUDE <= '0;
            GPS_LONGITUDE <= '0; GPS_HEIGHT <= '0; GPS_ALTITUDE <= '0;
            GPS_VISIBLE_SATS <= '0; GPS_TRACKED_SATS <= '0; GPS_LOCKED <= 1'b0;
            FRAME_VALID <= 1'b0; FRAME_OK_CNT <= '0; FRAME_ERR_CNT <= '0;
        end else begin
            FRAME_VALID <= commit;
            if (commit) begin
                GPS_YEAR <= sh_year; GPS_MONTH <= sh_month; GPS_DAY <= sh_day;
                GPS_HOUR <= sh_hour; GPS_MINUTES <= sh_min; GPS_SECOND <= sh_sec;
                GPS_LATITUDE <= sh_lat; GPS_LONGITUDE <= sh_lon;
                GPS_HEIGHT <= sh_height; GPS_ALTITUDE <= sh_alt;
                GPS_VISIBLE_SATS <= sh_vis; GPS_TRACKED_SATS <= sh_trk;
                GPS_LOCKED <= sh_locked;
                if (FRAME_OK_CNT != 16'hFFFF) FRAME_OK_CNT <= FRAME_OK_CNT + 16'd1;
            end
            if ((frame_bad || timeout_hit) && FRAME_ERR_CNT != 16'hFFFF)
                FRAME_ERR_CNT <= FRAME_ERR_CNT + 16'd1;
        end
    end

    logic pps_meta_reg, pps_sync_reg, pps_prev_reg;
    logic pps_rise;
    assign pps_rise = pps_sync_reg & ~pps_prev_reg;

    // Two-stage synchroniser on the asynchronous PPS input, then rising-edge strobe.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pps_meta_reg <= 1'b0;
            pps_sync_reg <= 1'b0;
            pps_prev_reg <= 1'b0;
            PPS_STROBE   <= 1'b0;
        end else begin
            pps_meta_reg <= GPS_PPS;
            pps_sync_reg <= pps_meta_reg;
            pps_prev_reg <= pps_sync_reg;
            PPS_STROBE   <= pps_rise;
        end
    end

`ifdef GPS_PPS_STAMP_EN
    logic [31:0] cycle_cnt_reg, stamp_reg;
    // Free-running cycle counter; the stamp holds the count of the strobe cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cycle_cnt_reg <= '0;
            stamp_reg     <= '0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            if (pps_rise) stamp_reg <= cycle_cnt_reg + 32'd1;
        end
    end
    assign PPS_STAMP = stamp_reg;
`else
    assign PPS_STAMP = '0;
`endif

endmodule

// File: tb/tb_gps_frame_parser.sv
// Testbench for gps_frame_parser. It builds frames from randomised field values,
// derives the expected decode from the frame bytes, and checks the outputs after
// every frame, around the timeout and PPS events, and after reset.
`timescale 1ns/1ps
module tb_gps_frame_parser;
    localparam int CH  = 12;
    localparam int FL  = 82 + 6 * CH;
    localparam int TMO = 20000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic        GPS_PPS = 1'b0;
    logic [15:0] GPS_YEAR;
    logic [7:0]  GPS_MONTH, GPS_DAY, GPS_HOUR, GPS_MINUTES, GPS_SECOND;
    logic [31:0] GPS_LATITUDE, GPS_LONGITUDE, GPS_HEIGHT, GPS_ALTITUDE;
    logic [7:0]  GPS_VISIBLE_SATS, GPS_TRACKED_SATS;
    logic        GPS_LOCKED, FRAME_VALID, PPS_STROBE;
    logic [15:0] FRAME_OK_CNT, FRAME_ERR_CNT;
    logic [31:0] PPS_STAMP;

    gps_frame_parser #(.CHANNELS(CH), .MSG_ID0(8'h48), .MSG_ID1(8'h61), .TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .GPS_PPS(GPS_PPS),
        .GPS_YEAR(GPS_YEAR), .GPS_MONTH(GPS_MONTH), .GPS_DAY(GPS_DAY), .GPS_HOUR(GPS_HOUR),
        .GPS_MINUTES(GPS_MINUTES), .GPS_SECOND(GPS_SECOND), .GPS_LATITUDE(GPS_LATITUDE),
        .GPS_LONGITUDE(GPS_LONGITUDE), .GPS_HEIGHT(GPS_HEIGHT), .GPS_ALTITUDE(GPS_ALTITUDE),
        .GPS_VISIBLE_SATS(GPS_VISIBLE_SATS), .GPS_TRACKED_SATS(GPS_TRACKED_SATS),
        .GPS_LOCKED(GPS_LOCKED), .FRAME_VALID(FRAME_VALID), .FRAME_OK_CNT(FRAME_OK_CNT),
        .FRAME_ERR_CNT(FRAME_ERR_CNT), .PPS_STROBE(PPS_STROBE), .PPS_STAMP(PPS_STAMP));

    always #50 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int fv_seen = 0;
    int e_fv = 0;
    logic [31:0] cyc = 0;

    // Count cycles with FRAME_VALID high, sampled just after the edge.
    always @(posedge CLK) begin
        #1;
        if (FRAME_VALID === 1'b1) fv_seen++;
    end

    // Cycles since reset release, compared against the PPS stamp.
    always @(posedge CLK) cyc <= RESET ? 32'd0 : cyc + 32'd1;

    // Expected published state.
    logic [15:0] e_year;
    logic [7:0]  e_month, e_day, e_hour, e_min, e_sec, e_vis, e_trk;
    logic [31:0] e_lat, e_lon, e_height, e_alt;
    logic        e_locked;
    int          e_ok, e_err;
    logic [7:0]  fb [FL];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        e_year = '0; e_month = '0; e_day = '0; e_hour = '0; e_min = '0; e_sec = '0;
        e_vis = '0; e_trk = '0; e_lat = '0; e_lon = '0; e_height = '0; e_alt = '0;
        e_locked = 1'b0; e_ok = 0; e_err = 0;
    endtask

    task automatic model_accept();
        e_month = fb[4];  e_day = fb[5];  e_year = {fb[6], fb[7]};
        e_hour = fb[8];   e_min = fb[9];  e_sec = fb[10];
        e_lat = {fb[15], fb[16], fb[17], fb[18]};
        e_lon = {fb[19], fb[20], fb[21], fb[22]};
        e_height = {fb[23], fb[24], fb[25], fb[26]};
        e_alt = {fb[27], fb[28], fb[29], fb[30]};
        e_vis = fb[55]; e_trk = fb[56];
        e_locked = 1'b0;
        for (int k = 0; k < CH; k++) e_locked = e_locked | fb[58 + 6 * k][3];
        e_ok++;
        e_fv++;
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".year"}, 32'(GPS_YEAR), 32'(e_year));
        check({ctx, ".month"}, 32'(GPS_MONTH), 32'(e_month));
        check({ctx, ".day"}, 32'(GPS_DAY), 32'(e_day));
        check({ctx, ".hour"}, 32'(GPS_HOUR), 32'(e_hour));
        check({ctx, ".min"}, 32'(GPS_MINUTES), 32'(e_min));
        check({ctx, ".sec"}, 32'(GPS_SECOND), 32'(e_sec));
        check({ctx, ".lat"}, GPS_LATITUDE, e_lat);
        check({ctx, ".lon"}, GPS_LONGITUDE, e_lon);
        check({ctx, ".height"}, GPS_HEIGHT, e_height);
        check({ctx, ".alt"}, GPS_ALTITUDE, e_alt);
        check({ctx, ".vis"}, 32'(GPS_VISIBLE_SATS), 32'(e_vis));
        check({ctx, ".trk"}, 32'(GPS_TRACKED_SATS), 32'(e_trk));
        check({ctx, ".locked"}, 32'(GPS_LOCKED), 32'(e_locked));
        check({ctx, ".ok_cnt"}, 32'(FRAME_OK_CNT), 32'(e_ok));
        check({ctx, ".err_cnt"}, 32'(FRAME_ERR_CNT), 32'(e_err));
        check({ctx, ".fv_count"}, 32'(fv_seen), 32'(e_fv));
    endtask

    // Random field bytes, channel lock bits cleared, optionally one channel locked.
    task automatic build_random();
        for (int i = 0; i < FL; i++) fb[i] = 8'($urandom_range(0, 255));
        fb[0] = 8'h40; fb[1] = 8'h40; fb[2] = 8'h48; fb[3] = 8'h61;
        for (int k = 0; k < CH; k++) fb[58 + 6 * k][3] = 1'b0;
        if ($urandom_range(0, 1) == 1) fb[58 + 6 * $urandom_range(0, CH - 1)][3] = 1'b1;
    endtask

    // kind: 0 good, 1 bad checksum, 2 bad CR, 3 bad LF.
    task automatic finalize(input int kind);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i <= FL - 4; i++) x = x ^ fb[i];
        fb[FL - 3] = x; fb[FL - 2] = 8'h0D; fb[FL - 1] = 8'h0A;
        if (kind == 1) fb[FL - 3] = x ^ 8'h01;
        if (kind == 2) fb[FL - 2] = 8'h0E;
        if (kind == 3) fb[FL - 1] = 8'h0B;
    endtask

    // Called at a negedge; drives one byte for one cycle, then idles 'gap' cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        RX_DATA = b; RX_VALID = 1'b1;
        @(negedge CLK);
        RX_VALID = 1'b0; RX_DATA = 8'($urandom_range(0, 255));
        repeat (gap) @(negedge CLK);
    endtask

    // Sends fb; gap < 0 picks random 1..3 idle cycles per byte.
    task automatic send_frame(input int kind, input int gap, input string ctx);
        for (int i = 0; i < FL - 1; i++) send_byte(fb[i], (gap < 0) ? $urandom_range(1, 3) : gap);
        send_byte(fb[FL - 1], 0);
        check({ctx, ".frame_valid"}, 32'(FRAME_VALID), (kind == 0) ? 32'd1 : 32'd0);
        if (kind == 0) model_accept();
        else e_err++;
        check_outputs(ctx);
        $display("[TB] %s kind=%0d ok=%0d err=%0d year=%h lat=%h locked=%0b",
                 ctx, kind, FRAME_OK_CNT, FRAME_ERR_CNT, GPS_YEAR, GPS_LATITUDE, GPS_LOCKED);
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] g;
        for (int i = 0; i < n; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'h40) g = 8'h41;
            send_byte(g, 1);
        end
    endtask

    initial begin
        int kind;
        model_clear();
        repeat (4) @(negedge CLK);
        check_outputs("reset");
        check("reset.pps_strobe", 32'(PPS_STROBE), 32'd0);
        check("reset.pps_stamp", PPS_STAMP, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // Reference frame, bytes 100 cycles apart.
        build_random();
        for (int k = 0; k < CH; k++) fb[58 + 6 * k][3] = 1'b0;
        fb[4] = 8'h06; fb[6] = 8'h07; fb[7] = 8'hE8;
        fb[15] = 8'h12; fb[16] = 8'h34; fb[17] = 8'h56; fb[18] = 8'h78;
        fb[58] = 8'h08;
        finalize(0);
        send_frame(0, 99, "ref");
        check("ref.year_const", 32'(GPS_YEAR), 32'h07E8);
        check("ref.lat_const", GPS_LATITUDE, 32'h12345678);
        check("ref.locked_const", 32'(GPS_LOCKED), 32'd1);

        // Same fields, new random payload, corrupted checksum.
        build_random();
        finalize(1);
        send_frame(1, -1, "bad_cksum");

        // "@@@Ha" then, back to back in the commit cycle, "@X@@Ha".
        build_random(); finalize(0);
        send_byte(8'h40, 2);
        send_frame(0, -1, "triple_at");
        build_random(); finalize(0);
        send_byte(8'h40, 1); send_byte(8'h58, 1);
        send_frame(0, -1, "at_x_prefix");

        // ID mismatch is silently dropped.
        send_byte(8'h40, 1); send_byte(8'h40, 1); send_byte(8'h48, 1); send_byte(8'h62, 1);
        build_random(); finalize(0);
        send_frame(0, -1, "id_mismatch");

        // Lock bit just outside the channel block, then in the last channel.
        build_random();
        for (int k = 0; k < CH; k++) fb[58 + 6 * k][3] = 1'b0;
        fb[58 + 6 * CH][3] = 1'b1;
        finalize(0);
        send_frame(0, -1, "lock_outside");
        check("lock_outside.locked_const", 32'(GPS_LOCKED), 32'd0);
        build_random();
        for (int k = 0; k < CH; k++) fb[58 + 6 * k][3] = 1'b0;
        fb[58 + 6 * (CH - 1)][3] = 1'b1;
        finalize(0);
        send_frame(0, -1, "lock_last");
        check("lock_last.locked_const", 32'(GPS_LOCKED), 32'd1);

        // Trailer errors.
        build_random(); finalize(2); send_frame(2, -1, "bad_cr");
        build_random(); finalize(3); send_frame(3, -1, "bad_lf");

        // Halt after byte 80: no error one cycle before the limit, error at it.
        build_random(); finalize(0);
        for (int i = 0; i <= 80; i++) send_byte(fb[i], (i == 80) ? 0 : 1);
        repeat (TMO - 1) @(negedge CLK);
        check("timeout.before", 32'(FRAME_ERR_CNT), 32'(e_err));
        @(negedge CLK);
        e_err++;
        check("timeout.at", 32'(FRAME_ERR_CNT), 32'(e_err));
        $display("[TB] timeout err=%0d", FRAME_ERR_CNT);
        build_random(); finalize(0);
        send_frame(0, -1, "after_timeout");

        // Randomised frames with garbage between them.
        for (int n = 0; n < 8; n++) begin
            send_garbage($urandom_range(0, 3));
            kind = $urandom_range(0, 5);
            kind = (kind < 3) ? 0 : kind - 2;
            build_random(); finalize(kind);
            send_frame(kind, -1, "random");
        end

        // PPS strobe three cycles after the input edge.
        repeat (5) @(negedge CLK);
        GPS_PPS = 1'b1;
        @(negedge CLK); check("pps.c1", 32'(PPS_STROBE), 32'd0);
        @(negedge CLK); check("pps.c2", 32'(PPS_STROBE), 32'd0);
        @(negedge CLK); check("pps.c3", 32'(PPS_STROBE), 32'd1);
`ifdef GPS_PPS_STAMP_EN
        check("pps.stamp", PPS_STAMP, cyc);
`else
        check("pps.stamp", PPS_STAMP, 32'd0);
`endif
        @(negedge CLK); check("pps.c4", 32'(PPS_STROBE), 32'd0);
        $display("[TB] pps strobe stamp=%0d cyc=%0d", PPS_STAMP, cyc);
        repeat (3) @(negedge CLK);
        GPS_PPS = 1'b0;
        repeat (5) @(negedge CLK);
        check("pps.fall", 32'(PPS_STROBE), 32'd0);

        // Reset mid-frame clears everything; parsing resumes afterwards.
        build_random(); finalize(0);
        for (int i = 0; i < 50; i++) send_byte(fb[i], 1);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        model_clear();
        check_outputs("mid_reset");
        RESET = 1'b0;
        @(negedge CLK);
        build_random(); finalize(0);
        send_frame(0, -1, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
